dti_apb_master: RTL and testbench

DTI_APB_MASTER -- requirements
Module: dti_apb_master

---
 rtl/dti_apb_master_pkg.sv | 15 +
 rtl/dti_apb_master_wdt.sv | 39 +++
 rtl/dti_apb_master.sv | 152 +++++++++++++++
 tb/tb_dti_apb_master.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dti_apb_master_pkg.sv
// Shared types and helpers for the DTI APB master: FSM state encoding and strobe width.
package dti_apb_master_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_ACCESS = 2'd2,
        ST_RESP   = 2'd3
    } apb_mst_state_e;

    function automatic int strb_width(input int data_width);
        return data_width / 8;
    endfunction

endpackage

// File: rtl/dti_apb_master_wdt.sv
// PREADY wait-state watchdog for the DTI APB master; only instantiated when
// APB_MASTER_TIMEOUT_EN is defined.
module dti_apb_master_wdt #(
    parameter int unsigned TIMEOUT_CYCLES = 256
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic inc,
    output logic expire
);

    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clear) begin
            cnt_d = '0;
        end else if (inc) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // Fires on the wait cycle that brings the count to TIMEOUT_CYCLES, so the
    // FSM leaves ACCESS after exactly TIMEOUT_CYCLES PREADY-low cycles.
    assign expire = inc && (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/dti_apb_master.sv
// Single-outstanding APB master driven by a valid/ready command port and returning a
// valid/ready response. Optional PREADY watchdog enabled by defining APB_MASTER_TIMEOUT_EN.
module dti_apb_master
    import dti_apb_master_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH     = 32,
    parameter int unsigned DATA_WIDTH     = 32,
    parameter int unsigned TIMEOUT_CYCLES = 256
) (
    input  logic                    PCLK,
    input  logic                    PRESETn,
    input  logic                    cmd_valid,
    output logic                    cmd_ready,
    input  logic                    cmd_write,
    input  logic [ADDR_WIDTH-1:0]   cmd_addr,
    input  logic [DATA_WIDTH-1:0]   cmd_wdata,
    input  logic [DATA_WIDTH/8-1:0] cmd_strb,
    output logic                    rsp_valid,
    input  logic                    rsp_ready,
    output logic [DATA_WIDTH-1:0]   rsp_rdata,
    output logic                    rsp_err,
    output logic                    rsp_timeout,
    output logic [ADDR_WIDTH-1:0]   PADDR,
    output logic [DATA_WIDTH-1:0]   PWDATA,
    output logic [DATA_WIDTH/8-1:0] PSTRB,
    output logic                    PSEL,
    output logic                    PENABLE,
    output logic                    PWRITE,
    input  logic [DATA_WIDTH-1:0]   PRDATA,
    input  logic                    PREADY,
    input  logic                    PSLVERR
);

    localparam int STRB_W = strb_width(DATA_WIDTH);

    apb_mst_state_e          state_q, state_d;
    logic                    cmd_ready_q, cmd_ready_d;
    logic [ADDR_WIDTH-1:0]   paddr_q, paddr_d;
    logic [DATA_WIDTH-1:0]   pwdata_q, pwdata_d;
    logic [STRB_W-1:0]       pstrb_q, pstrb_d;
    logic                    pwrite_q, pwrite_d;
    logic [DATA_WIDTH-1:0]   rsp_rdata_q, rsp_rdata_d;
    logic                    rsp_err_q, rsp_err_d;
    logic                    rsp_timeout_q, rsp_timeout_d;
    logic                    tmo_expire;

`ifdef APB_MASTER_TIMEOUT_EN
    dti_apb_master_wdt #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_wdt (
        .clk    (PCLK),
        .rst_n  (PRESETn),
        .clear  (state_q == ST_SETUP),
        .inc    ((state_q == ST_ACCESS) && !PREADY),
        .expire (tmo_expire)
    );
`else
    assign tmo_expire = 1'b0;
`endif

    always_comb begin
        state_d       = state_q;
        paddr_d       = paddr_q;
        pwdata_d      = pwdata_q;
        pstrb_d       = pstrb_q;
        pwrite_d      = pwrite_q;
        rsp_rdata_d   = rsp_rdata_q;
        rsp_err_d     = rsp_err_q;
        rsp_timeout_d = rsp_timeout_q;

        unique case (state_q)
            ST_IDLE: begin
                if (cmd_valid && cmd_ready_q) begin
                    paddr_d  = cmd_addr;
                    pwrite_d = cmd_write;
                    // Reads keep the last write data on the bus and drive no strobes.
                    if (cmd_write) begin
                        pwdata_d = cmd_wdata;
                        pstrb_d  = cmd_strb;
                    end else begin
                        pstrb_d  = '0;
                    end
                    state_d = ST_SETUP;
                end
            end
            ST_SETUP: begin
                state_d = ST_ACCESS;
            end
            ST_ACCESS: begin
                if (PREADY) begin
                    rsp_err_d     = PSLVERR;
                    rsp_rdata_d   = pwrite_q ? '0 : PRDATA;
                    rsp_timeout_d = 1'b0;
                    state_d       = ST_RESP;
                end else if (tmo_expire) begin
                    rsp_err_d     = 1'b1;
                    rsp_rdata_d   = '0;
                    rsp_timeout_d = 1'b1;
                    state_d       = ST_RESP;
                end
            end
            ST_RESP: begin
                if (rsp_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Registered so it is 0 through reset and rises on the first edge after release.
        cmd_ready_d = (state_d == ST_IDLE);
    end

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            state_q       <= ST_IDLE;
            cmd_ready_q   <= 1'b0;
            paddr_q       <= '0;
            pwdata_q      <= '0;
            pstrb_q       <= '0;
            pwrite_q      <= 1'b0;
            rsp_rdata_q   <= '0;
            rsp_err_q     <= 1'b0;
            rsp_timeout_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            cmd_ready_q   <= cmd_ready_d;
            paddr_q       <= paddr_d;
            pwdata_q      <= pwdata_d;
            pstrb_q       <= pstrb_d;
            pwrite_q      <= pwrite_d;
            rsp_rdata_q   <= rsp_rdata_d;
            rsp_err_q     <= rsp_err_d;
            rsp_timeout_q <= rsp_timeout_d;
        end
    end

    assign cmd_ready   = cmd_ready_q;
    assign PSEL        = (state_q == ST_SETUP) || (state_q == ST_ACCESS);
    assign PENABLE     = (state_q == ST_ACCESS);
    assign rsp_valid   = (state_q == ST_RESP);
    assign PADDR       = paddr_q;
    assign PWDATA      = pwdata_q;
    assign PSTRB       = pstrb_q;
    assign PWRITE      = pwrite_q;
    assign rsp_rdata   = rsp_rdata_q;
    assign rsp_err     = rsp_err_q;
    assign rsp_timeout = rsp_timeout_q;

endmodule

// File: tb/tb_dti_apb_master.sv
// Self-checking bench for dti_apb_master: table of APB transfers with a response
// scoreboard, plus reset-mid-transfer and (with APB_MASTER_TIMEOUT_EN) watchdog cases.
module tb_dti_apb_master;

    logic        PCLK = 1'b0;
    logic        PRESETn;
    logic        cmd_valid, cmd_ready, cmd_write;
    logic [31:0] cmd_addr, cmd_wdata;
    logic [3:0]  cmd_strb;
    logic        rsp_valid, rsp_ready, rsp_err, rsp_timeout;
    logic [31:0] rsp_rdata;
    logic [31:0] PADDR, PWDATA, PRDATA;
    logic [3:0]  PSTRB;
    logic        PSEL, PENABLE, PWRITE, PREADY, PSLVERR;

    dti_apb_master #(
        .ADDR_WIDTH     (32),
        .DATA_WIDTH     (32),
        .TIMEOUT_CYCLES (8)
    ) dut (
        .PCLK        (PCLK),
        .PRESETn     (PRESETn),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd_write   (cmd_write),
        .cmd_addr    (cmd_addr),
        .cmd_wdata   (cmd_wdata),
        .cmd_strb    (cmd_strb),
        .rsp_valid   (rsp_valid),
        .rsp_ready   (rsp_ready),
        .rsp_rdata   (rsp_rdata),
        .rsp_err     (rsp_err),
        .rsp_timeout (rsp_timeout),
        .PADDR       (PADDR),
        .PWDATA      (PWDATA),
        .PSTRB       (PSTRB),
        .PSEL        (PSEL),
        .PENABLE     (PENABLE),
        .PWRITE      (PWRITE),
        .PRDATA      (PRDATA),
        .PREADY      (PREADY),
        .PSLVERR     (PSLVERR)
    );

    always #5 PCLK = ~PCLK;

    typedef struct {
        logic        write;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  strb;
        int          waits;
        logic        tmo;
        logic [31:0] prdata;
        logic        slverr;
        int          rsp_delay;
        logic        hold;
        logic [31:0] exp_rdata;
        logic        exp_err;
        logic        exp_tmo;
    } vec_t;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        logic        tmo;
    } exp_t;

    vec_t        vecs[$];
    exp_t        sb[$];
    int          checks   = 0;
    int          failures = 0;
    logic [31:0] last_wdata;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h at %0t", name, act, req, $time);
        end
    endtask

    function automatic vec_t mk(input logic w, input logic [31:0] a, input logic [31:0] wd,
                                input logic [3:0] s, input int wt, input logic tm,
                                input logic [31:0] prd, input logic se, input int rd,
                                input logic hd, input logic [31:0] er, input logic ee,
                                input logic et);
        vec_t v;
        v.write = w; v.addr = a; v.wdata = wd; v.strb = s; v.waits = wt; v.tmo = tm;
        v.prdata = prd; v.slverr = se; v.rsp_delay = rd; v.hold = hd;
        v.exp_rdata = er; v.exp_err = ee; v.exp_tmo = et;
        return v;
    endfunction

    task automatic next_cycle();
        @(posedge PCLK);
        #1;
    endtask

    task automatic do_reset();
        PRESETn = 1'b0;
        repeat (3) next_cycle();
        PRESETn = 1'b1;
        last_wdata = '0;
        sb.delete();
    endtask

    task automatic bus_checks(input string tag, input logic sel, input logic en,
                              input vec_t v, input logic [31:0] exp_pwdata);
        chk({tag, "_psel"}, PSEL, sel);
        chk({tag, "_penable"}, PENABLE, en);
        chk({tag, "_paddr"}, PADDR, v.addr);
        chk({tag, "_pwrite"}, PWRITE, v.write);
        chk({tag, "_pstrb"}, PSTRB, v.write ? v.strb : 4'h0);
        chk({tag, "_pwdata"}, PWDATA, exp_pwdata);
        chk({tag, "_cmd_ready"}, cmd_ready, 1'b0);
        chk({tag, "_rsp_valid"}, rsp_valid, 1'b0);
    endtask

    task automatic run_txn(input vec_t v);
        logic [31:0] exp_pwdata;
        exp_t        e;
        int          guard;

        exp_pwdata = v.write ? v.wdata : last_wdata;
        guard = 0;
        while (cmd_ready !== 1'b1 && guard < 20) begin
            next_cycle();
            guard++;
        end
        chk("idle_cmd_ready", cmd_ready, 1'b1);

        cmd_valid = 1'b1; cmd_write = v.write; cmd_addr = v.addr;
        cmd_wdata = v.wdata; cmd_strb = v.strb;
        e.rdata = v.exp_rdata; e.err = v.exp_err; e.tmo = v.exp_tmo;
        sb.push_back(e);
        next_cycle();

        if (v.hold) begin
            cmd_write = ~v.write; cmd_addr = ~v.addr; cmd_wdata = ~v.wdata; cmd_strb = ~v.strb;
        end else begin
            cmd_valid = 1'b0;
        end
        bus_checks("setup", 1'b1, 1'b0, v, exp_pwdata);
        // Completion-looking inputs outside ACCESS must be ignored.
        PREADY = 1'b1; PSLVERR = 1'b1; PRDATA = 32'h5EED5EED;
        next_cycle();

        PREADY = 1'b0; PSLVERR = 1'b0;
        for (int i = 0; i < v.waits; i++) begin
            bus_checks("access_wait", 1'b1, 1'b1, v, exp_pwdata);
            next_cycle();
        end
        if (!v.tmo) begin
            bus_checks("access_done", 1'b1, 1'b1, v, exp_pwdata);
            PREADY = 1'b1; PRDATA = v.prdata; PSLVERR = v.slverr;
            next_cycle();
            PREADY = 1'b0; PSLVERR = 1'b0; PRDATA = 32'h5EED5EED;
        end

        chk("rsp_latency", rsp_valid, 1'b1);
        guard = 0;
        while (rsp_valid !== 1'b1 && guard < 50) begin
            next_cycle();
            guard++;
        end
        if (rsp_valid !== 1'b1) begin
            checks++;
            failures++;
            $display("FAIL rsp_wait actual=no_response required=response_within_50_cycles");
            cmd_valid = 1'b0;
            do_reset();
            return;
        end

        e = sb.pop_front();
        for (int d = 0; d <= v.rsp_delay; d++) begin
            chk("resp_rdata", rsp_rdata, e.rdata);
            chk("resp_err", rsp_err, e.err);
            chk("resp_timeout", rsp_timeout, e.tmo);
            chk("resp_valid", rsp_valid, 1'b1);
            chk("resp_psel", PSEL, 1'b0);
            chk("resp_penable", PENABLE, 1'b0);
            chk("resp_cmd_ready", cmd_ready, 1'b0);
            if (d < v.rsp_delay) begin
                rsp_ready = 1'b0;
                next_cycle();
            end
        end
        rsp_ready = 1'b1;
        next_cycle();
        rsp_ready = 1'b0;
        cmd_valid = 1'b0;

        chk("post_rsp_valid", rsp_valid, 1'b0);
        chk("post_psel", PSEL, 1'b0);
        chk("post_cmd_ready", cmd_ready, 1'b1);
        if (v.write) last_wdata = v.wdata;
    endtask

    initial begin
        #200000;
        $display("FAIL global_time_limit actual=running required=finished");
        $fatal(1, "time limit");
    end

    initial begin
        PRESETn = 1'b0; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0;
        cmd_wdata = '0; cmd_strb = '0; rsp_ready = 1'b0; PRDATA = '0;
        PREADY = 1'b0; PSLVERR = 1'b0; last_wdata = '0;

        //      wr    addr          wdata         strb  wt  tmo   prdata        err  rd  hold  exp_rdata    eerr  etmo
        vecs.push_back(mk(1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 4'hF, 0, 1'b0, 32'h0,        1'b0, 0, 1'b0, 32'h0,        1'b0, 1'b0));
        vecs.push_back(mk(1'b0, 32'h0000_0020, 32'h0,         4'h0, 3, 1'b0, 32'h1234_5678, 1'b0, 0, 1'b0, 32'h1234_5678, 1'b0, 1'b0));
        vecs.push_back(mk(1'b0, 32'h0000_0030, 32'h0,         4'h0, 0, 1'b0, 32'hA5A5_A5A5, 1'b1, 1, 1'b0, 32'hA5A5_A5A5, 1'b1, 1'b0));
        vecs.push_back(mk(1'b1, 32'h0000_0044, 32'h0102_0304, 4'h5, 2, 1'b0, 32'h7777_7777, 1'b1, 5, 1'b1, 32'h0,        1'b1, 1'b0));
        vecs.push_back(mk(1'b0, 32'hFFFF_FFFC, 32'h0,         4'h0, 1, 1'b0, 32'hFFFF_FFFF, 1'b0, 2, 1'b1, 32'hFFFF_FFFF, 1'b0, 1'b0));
        vecs.push_back(mk(1'b1, 32'h0000_0000, 32'h0000_0000, 4'h0, 0, 1'b0, 32'h0,        1'b0, 0, 1'b0, 32'h0,        1'b0, 1'b0));
`ifdef APB_MASTER_TIMEOUT_EN
        vecs.push_back(mk(1'b0, 32'h0000_0100, 32'h0,         4'h0, 7, 1'b0, 32'hCAFE_F00D, 1'b0, 0, 1'b0, 32'hCAFE_F00D, 1'b0, 1'b0));
        vecs.push_back(mk(1'b0, 32'h0000_0104, 32'h0,         4'h0, 8, 1'b1, 32'h0,        1'b0, 3, 1'b0, 32'h0,        1'b1, 1'b1));
        vecs.push_back(mk(1'b1, 32'h0000_0108, 32'h1111_2222, 4'hC, 8, 1'b1, 32'h0,        1'b0, 0, 1'b0, 32'h0,        1'b1, 1'b1));
`else
        vecs.push_back(mk(1'b0, 32'h0000_0100, 32'h0,         4'h0, 20, 1'b0, 32'h0BAD_F00D, 1'b0, 0, 1'b0, 32'h0BAD_F00D, 1'b0, 1'b0));
`endif

        // Reset values while PRESETn is held low across several edges.
        repeat (3) next_cycle();
        chk("rst_psel", PSEL, 1'b0);
        chk("rst_penable", PENABLE, 1'b0);
        chk("rst_pwrite", PWRITE, 1'b0);
        chk("rst_paddr", PADDR, 32'h0);
        chk("rst_pwdata", PWDATA, 32'h0);
        chk("rst_pstrb", PSTRB, 4'h0);
        chk("rst_rsp_valid", rsp_valid, 1'b0);
        chk("rst_rsp_rdata", rsp_rdata, 32'h0);
        chk("rst_rsp_err", rsp_err, 1'b0);
        chk("rst_rsp_timeout", rsp_timeout, 1'b0);
        chk("rst_cmd_ready", cmd_ready, 1'b0);
        #2;
        PRESETn = 1'b1;
        next_cycle();
        chk("release_cmd_ready", cmd_ready, 1'b1);

        for (int i = 0; i < vecs.size(); i++) begin
            run_txn(vecs[i]);
        end

        // Reset asserted mid-ACCESS: bus drops asynchronously and no response follows.
        cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 32'h0000_0080;
        next_cycle();
        cmd_valid = 1'b0;
        chk("mid_setup_psel", PSEL, 1'b1);
        next_cycle();
        chk("mid_access_penable", PENABLE, 1'b1);
        #2;
        PRESETn = 1'b0;
        #1;
        chk("async_rst_psel", PSEL, 1'b0);
        chk("async_rst_penable", PENABLE, 1'b0);
        chk("async_rst_rsp_valid", rsp_valid, 1'b0);
        PREADY = 1'b1;
        @(posedge PCLK);
        #3;
        PRESETn = 1'b1;
        PREADY = 1'b0;
        last_wdata = '0;
        next_cycle();
        chk("mid_release_cmd_ready", cmd_ready, 1'b1);
        for (int i = 0; i < 3; i++) begin
            chk("mid_no_rsp", rsp_valid, 1'b0);
            chk("mid_no_psel", PSEL, 1'b0);
            next_cycle();
        end

        run_txn(vecs[1]);
        chk("scoreboard_empty", sb.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
